// File: rtl/bram_burst_reader.sv
// Burst read master for BRAM port B. A start command fetches `length` consecutive
// words from `base_addr` and presents them on a valid/ready stream. A small skid
// FIFO absorbs the fixed read latency. A credit check keeps the FIFO from overflowing.
module bram_burst_reader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  // One slot per read that can be in the BRAM pipeline, plus one for the head beat.
  localparam int unsigned Depth = RD_LAT + 1;
  localparam int unsigned PtrW  = $clog2(Depth);
  localparam int unsigned CntW  = $clog2(Depth + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFin} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W:0]     len_q;
  logic [ADDR_W:0]     issued_q;
  logic [ADDR_W:0]     accepted_q;
  logic [ADDR_W-1:0]   addr_hold_q;
  logic [RD_LAT-1:0]   vld_q, vld_d;
  logic [DATA_W-1:0]   fifo_q [Depth];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     cnt_q;

  logic                issue;
  logic                pop;
  logic                capture;
  logic                last_issue;
  logic                last_beat;
  logic [CntW:0]       inflight;
  logic [CntW:0]       occ;
  logic [ADDR_W-1:0]   issue_addr;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign m_valid    = (cnt_q != '0);
  assign pop        = m_valid && m_ready;
  assign capture    = vld_q[RD_LAT-1];
  assign issue_addr = base_q + issued_q[ADDR_W-1:0];
  assign last_issue = (issued_q == len_q - 1'b1);
  assign last_beat  = (accepted_q == len_q - 1'b1);
  assign m_data     = fifo_q[rd_ptr_q];
  assign m_last     = m_valid && last_beat;
  assign bram_addr  = bram_en ? issue_addr : addr_hold_q;

  // Count reads still in the BRAM pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(RD_LAT); i++) begin
      inflight = inflight + {{CntW{1'b0}}, vld_q[i]};
    end
  end

  // Credit: a beat leaving this cycle frees its slot, so full rate is sustained.
  always_comb begin
    occ   = {1'b0, cnt_q} + inflight - {{CntW{1'b0}}, pop};
    issue = (state_q == StIssue) && (occ < (CntW + 1)'(Depth));
  end

  // Valid-tag shift register that marks when read data appears on bram_dout.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = issue;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  // Next-state logic and status/issue outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    bram_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = (length == '0) ? StFin : StIssue;
      end
      StIssue: begin
        busy    = 1'b1;
        bram_en = issue;
        if (issue && last_issue) state_d = StDrain;
      end
      StDrain: begin
        busy = 1'b1;
        if (pop && last_beat) state_d = StFin;
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Command capture and issue/accept counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      base_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      accepted_q  <= '0;
      addr_hold_q <= '0;
    end else begin
      if (state_q == StIdle && start) begin
        base_q     <= base_addr;
        len_q      <= length;
        issued_q   <= '0;
        accepted_q <= '0;
      end else begin
        if (issue) issued_q   <= issued_q + 1'b1;
        if (pop)   accepted_q <= accepted_q + 1'b1;
      end
      if (issue) addr_hold_q <= issue_addr;
    end
  end

  // Read-data pipeline tags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) vld_q <= '0;
    else         vld_q <= vld_d;
  end

  // Skid FIFO: capture returning words, release on handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(Depth); i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (capture) begin
        fifo_q[wr_ptr_q] <= bram_dout;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({capture, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_burst_reader.sv
// Bench for bram_burst_reader: runs an RD_LAT=1 and an RD_LAT=2 instance side by
// side on shared stimulus. Each instance has its own BRAM model and scoreboards.
module tb_bram_burst_reader;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] length;
  logic        m_ready;

  logic       busy_a, done_a, bram_en_a, m_valid_a, m_last_a;
  logic [9:0] bram_addr_a;
  logic [7:0] bram_dout_a, m_data_a;
  logic       busy_b, done_b, bram_en_b, m_valid_b, m_last_b;
  logic [9:0] bram_addr_b;
  logic [7:0] bram_dout_b, m_data_b, pipe_b;

  int checks = 0;
  int passes = 0;

  logic [8:0] beat_q_a[$];
  logic [8:0] beat_q_b[$];
  logic [9:0] addr_q_a[$];
  logic [9:0] addr_q_b[$];

  always #5 clk = ~clk;

  bram_burst_reader #(.ADDR_W(10), .DATA_W(8), .RD_LAT(1)) dut_a (
    .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy_a), .done(done_a), .bram_en(bram_en_a), .bram_addr(bram_addr_a),
    .bram_dout(bram_dout_a), .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a),
    .m_last(m_last_a)
  );

  bram_burst_reader #(.ADDR_W(10), .DATA_W(8), .RD_LAT(2)) dut_b (
    .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy_b), .done(done_b), .bram_en(bram_en_b), .bram_addr(bram_addr_b),
    .bram_dout(bram_dout_b), .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b),
    .m_last(m_last_b)
  );

  // Memory contents: low addresses read back as their own index; bits 9:8 flip data.
  function automatic logic [7:0] mem_val(input logic [9:0] a);
    return a[7:0] ^ {a[9:8], 6'b0};
  endfunction

  always_ff @(posedge clk) begin
    if (bram_en_a) bram_dout_a <= mem_val(bram_addr_a);
  end

  always_ff @(posedge clk) begin
    if (bram_en_b) pipe_b <= mem_val(bram_addr_b);
    bram_dout_b <= pipe_b;
  end

  // Scoreboard for instance A: addresses, beats, stall stability.
  always @(negedge clk) begin : mon_a
    logic [9:0] ea;
    logic [8:0] eb;
    logic       held;
    logic [8:0] held_val;
    if (!resetn) begin
      held = 1'b0;
    end else begin
      if (bram_en_a) begin
        checks++;
        if (addr_q_a.size() == 0) $display("FAIL addr_a: issued %0d, none expected", bram_addr_a);
        else begin
          ea = addr_q_a.pop_front();
          if (bram_addr_a !== ea) $display("FAIL addr_a: got %0d want %0d", bram_addr_a, ea);
          else passes++;
        end
      end
      if (held) begin
        checks++;
        if ({m_valid_a, m_last_a, m_data_a} !== {1'b1, held_val})
          $display("FAIL stall_a: got v%0b %h want v1 %h", m_valid_a, {m_last_a, m_data_a},
                   held_val);
        else passes++;
      end
      if (m_valid_a && m_ready) begin
        checks++;
        if (beat_q_a.size() == 0) $display("FAIL beat_a: got %h, none expected", m_data_a);
        else begin
          eb = beat_q_a.pop_front();
          if ({m_last_a, m_data_a} !== eb)
            $display("FAIL beat_a: got %h want %h", {m_last_a, m_data_a}, eb);
          else passes++;
        end
      end
      held     = m_valid_a && !m_ready;
      held_val = {m_last_a, m_data_a};
    end
  end

  // Scoreboard for instance B.
  always @(negedge clk) begin : mon_b
    logic [9:0] ea;
    logic [8:0] eb;
    logic       held;
    logic [8:0] held_val;
    if (!resetn) begin
      held = 1'b0;
    end else begin
      if (bram_en_b) begin
        checks++;
        if (addr_q_b.size() == 0) $display("FAIL addr_b: issued %0d, none expected", bram_addr_b);
        else begin
          ea = addr_q_b.pop_front();
          if (bram_addr_b !== ea) $display("FAIL addr_b: got %0d want %0d", bram_addr_b, ea);
          else passes++;
        end
      end
      if (held) begin
        checks++;
        if ({m_valid_b, m_last_b, m_data_b} !== {1'b1, held_val})
          $display("FAIL stall_b: got v%0b %h want v1 %h", m_valid_b, {m_last_b, m_data_b},
                   held_val);
        else passes++;
      end
      if (m_valid_b && m_ready) begin
        checks++;
        if (beat_q_b.size() == 0) $display("FAIL beat_b: got %h, none expected", m_data_b);
        else begin
          eb = beat_q_b.pop_front();
          if ({m_last_b, m_data_b} !== eb)
            $display("FAIL beat_b: got %h want %h", {m_last_b, m_data_b}, eb);
          else passes++;
        end
      end
      held     = m_valid_b && !m_ready;
      held_val = {m_last_b, m_data_b};
    end
  end

  task automatic push_burst(input logic [9:0] b, input logic [10:0] l);
    logic [9:0] a;
    for (int k = 0; k < int'(l); k++) begin
      a = b + 10'(k);
      addr_q_a.push_back(a);
      addr_q_b.push_back(a);
      beat_q_a.push_back({k == int'(l) - 1, mem_val(a)});
      beat_q_b.push_back({k == int'(l) - 1, mem_val(a)});
    end
  endtask

  // Leaves the bench 1 ns into cycle 1 (start sampled at the edge ending cycle 0).
  task automatic do_start(input logic [9:0] b, input logic [10:0] l);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = b;
    length    = l;
    push_burst(b, l);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, input bit toggle, output bit ok);
    bit got_a = 1'b0;
    bit got_b = 1'b0;
    for (int i = 0; i < max && !(got_a && got_b); i++) begin
      @(posedge clk);
      #1;
      if (toggle) m_ready = ~m_ready;
      @(negedge clk);
      if (done_a) got_a = 1'b1;
      if (done_b) got_b = 1'b1;
    end
    ok = got_a && got_b;
    @(posedge clk);
    #1;
    m_ready = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b1;
    #2;
    checks++;
    if ({busy_a, done_a, bram_en_a, bram_addr_a, m_valid_a, m_data_a, m_last_a} !== '0)
      $display("FAIL reset_a: got %b want 0",
               {busy_a, done_a, bram_en_a, bram_addr_a, m_valid_a, m_data_a, m_last_a});
    else passes++;
    checks++;
    if ({busy_b, done_b, bram_en_b, bram_addr_b, m_valid_b, m_data_b, m_last_b} !== '0)
      $display("FAIL reset_b: got %b want 0",
               {busy_b, done_b, bram_en_b, bram_addr_b, m_valid_b, m_data_b, m_last_b});
    else passes++;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  // Cycle-exact timing of a 4-word burst; order per cycle: en, valid, last, done, busy.
  task automatic test_basic();
    logic [4:0] exp_a, exp_b;
    do_start(10'd0, 11'd4);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      exp_a = {c <= 4, c >= 3 && c <= 6, c == 6, c == 7, c <= 6};
      exp_b = {c <= 4, c >= 4 && c <= 7, c == 7, c == 8, c <= 7};
      checks++;
      if ({bram_en_a, m_valid_a, m_last_a, done_a, busy_a} !== exp_a)
        $display("FAIL basic_a cycle %0d: got %b want %b", c,
                 {bram_en_a, m_valid_a, m_last_a, done_a, busy_a}, exp_a);
      else passes++;
      checks++;
      if ({bram_en_b, m_valid_b, m_last_b, done_b, busy_b} !== exp_b)
        $display("FAIL basic_b cycle %0d: got %b want %b", c,
                 {bram_en_b, m_valid_b, m_last_b, done_b, busy_b}, exp_b);
      else passes++;
    end
    checks++;
    if (beat_q_a.size() + beat_q_b.size() + addr_q_a.size() + addr_q_b.size() != 0)
      $display("FAIL basic_drain: %0d entries left, want 0",
               beat_q_a.size() + beat_q_b.size() + addr_q_a.size() + addr_q_b.size());
    else passes++;
  endtask

  task automatic test_burst(input string name, input logic [9:0] b, input logic [10:0] l,
                            input bit toggle, input int max);
    bit ok;
    do_start(b, l);
    wait_done(max, toggle, ok);
    checks++;
    if (!ok) $display("FAIL %s_done: got timeout want done", name);
    else passes++;
    checks++;
    if (beat_q_a.size() + beat_q_b.size() + addr_q_a.size() + addr_q_b.size() != 0)
      $display("FAIL %s_drain: %0d entries left, want 0", name,
               beat_q_a.size() + beat_q_b.size() + addr_q_a.size() + addr_q_b.size());
    else passes++;
  endtask

  task automatic test_zero_len();
    do_start(10'd5, 11'd0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if ({bram_en_a, m_valid_a, done_a, busy_a, bram_en_b, m_valid_b, done_b, busy_b} !==
          {1'b0, 1'b0, c == 1, 1'b0, 1'b0, 1'b0, c == 1, 1'b0})
        $display("FAIL zero_len cycle %0d: got %b want done=%0b only", c,
                 {bram_en_a, m_valid_a, done_a, busy_a, bram_en_b, m_valid_b, done_b, busy_b},
                 c == 1);
      else passes++;
    end
  endtask

  task automatic test_ignore_start();
    bit ok;
    do_start(10'd100, 11'd6);
    @(posedge clk);
    #1;
    start = 1'b1; base_addr = 10'd500; length = 11'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(60, 1'b0, ok);
    checks++;
    if (!ok) $display("FAIL ignore_done: got timeout want done");
    else passes++;
    checks++;
    if (beat_q_a.size() + beat_q_b.size() + addr_q_a.size() + addr_q_b.size() != 0)
      $display("FAIL ignore_drain: %0d entries left, want 0",
               beat_q_a.size() + beat_q_b.size() + addr_q_a.size() + addr_q_b.size());
    else passes++;
    test_burst("restart", 10'd300, 11'd2, 1'b0, 40);
  endtask

  task automatic test_stall();
    bit ok;
    int en_a = 0;
    int en_b = 0;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    do_start(10'd40, 11'd12);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      en_a += int'(bram_en_a);
      en_b += int'(bram_en_b);
    end
    checks++;
    if (en_a != 2) $display("FAIL stall_credit_a: got %0d issues want 2", en_a);
    else passes++;
    checks++;
    if (en_b != 3) $display("FAIL stall_credit_b: got %0d issues want 3", en_b);
    else passes++;
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    wait_done(100, 1'b0, ok);
    checks++;
    if (!ok) $display("FAIL stall_done: got timeout want done");
    else passes++;
    checks++;
    if (beat_q_a.size() + beat_q_b.size() + addr_q_a.size() + addr_q_b.size() != 0)
      $display("FAIL stall_drain: %0d entries left, want 0",
               beat_q_a.size() + beat_q_b.size() + addr_q_a.size() + addr_q_b.size());
    else passes++;
  endtask

  task automatic test_reset_mid();
    do_start(10'd0, 11'd20);
    repeat (4) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    checks++;
    if ({busy_a, done_a, bram_en_a, bram_addr_a, m_valid_a, m_data_a, m_last_a,
         busy_b, done_b, bram_en_b, bram_addr_b, m_valid_b, m_data_b, m_last_b} !== '0)
      $display("FAIL reset_mid: got %b want 0",
               {busy_a, done_a, bram_en_a, bram_addr_a, m_valid_a, m_data_a, m_last_a,
                busy_b, done_b, bram_en_b, bram_addr_b, m_valid_b, m_data_b, m_last_b});
    else passes++;
    beat_q_a.delete(); beat_q_b.delete(); addr_q_a.delete(); addr_q_b.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({done_a, busy_a, m_valid_a, bram_en_a, done_b, busy_b, m_valid_b, bram_en_b} !== '0)
        $display("FAIL post_reset cycle %0d: got %b want 0", c,
                 {done_a, busy_a, m_valid_a, bram_en_a, done_b, busy_b, m_valid_b, bram_en_b});
      else passes++;
    end
    test_burst("recover", 10'd5, 11'd3, 1'b0, 40);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_burst("backpressure", 10'd16, 11'd8, 1'b1, 200);
    test_burst("wrap", 10'd1022, 11'd4, 1'b0, 50);
    test_zero_len();
    test_burst("full", 10'd0, 11'd1024, 1'b0, 1300);
    test_ignore_start();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
